// File: rtl/bmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bmp_pkg
//  Description : Shared constants, serializer state encoding and BMP row
//                padding helpers for the BMP frame writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package bmp_pkg;

    localparam int BYTES_PER_PIX = 3;
    localparam int BMP_ROW_ALIGN = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PIX  = 2'd1,
        S_PAD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Zero bytes appended to each row so that rows start on a 4-byte boundary.
    function automatic int pad_bytes(input int width);
        return (BMP_ROW_ALIGN - (width * BYTES_PER_PIX) % BMP_ROW_ALIGN) % BMP_ROW_ALIGN;
    endfunction

    // Stored bytes per row, including padding.
    function automatic int row_bytes(input int width);
        return width * BYTES_PER_PIX + pad_bytes(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pix_pair_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pix_pair_fifo
//  Description : Synchronous FIFO of tagged pixel pairs. Fall-through read
//                data, synchronous flush, and a push into a full FIFO is
//                accepted when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module pix_pair_fifo #(
    parameter int DW    = 69,
    parameter int DEPTH = 16
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;

    logic w_do_pop;
    logic w_do_push;

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign rdata_o   = mem_q[rptr_q];
    assign w_do_pop  = pop_i & ~empty_o & ~flush_i;
    assign w_do_push = push_i & (~full_o | w_do_pop) & ~flush_i;

    // Storage array: written on every accepted push.
    always_ff @(posedge HCLK) begin
        if (w_do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; flush empties the FIFO in one cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (w_do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (w_do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bmp_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : bmp_frame_writer
//  Description : Captures RGB888 pixel pairs, tags them with row/column,
//                buffers them, and serializes BMP-ordered bytes (B,G,R,
//                bottom-up rows, zero row padding) with pixel-array byte
//                addresses over a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module bmp_frame_writer
    import bmp_pkg::*;
#(
    parameter int WIDTH      = 768,
    parameter int HEIGHT     = 512,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 21
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              VSYNC,
    input  logic              HSYNC,
    input  logic [7:0]        DATA_R0,
    input  logic [7:0]        DATA_G0,
    input  logic [7:0]        DATA_B0,
    input  logic [7:0]        DATA_R1,
    input  logic [7:0]        DATA_G1,
    input  logic [7:0]        DATA_B1,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [7:0]        o_byte,
    output logic [ADDR_W-1:0] o_addr,
    output logic              frame_done,
    output logic              overflow
);

    localparam int PAD       = pad_bytes(WIDTH);
    localparam int ROW_BYTES = row_bytes(WIDTH);
    localparam int ROW_W     = $clog2(HEIGHT) + 1;
    localparam int COL_W     = $clog2(WIDTH) + 1;
    localparam int ENTRY_W   = 48 + ROW_W + COL_W;

    // ------------------------------------------------------------------
    // Frame start detection and capture side
    // ------------------------------------------------------------------
    logic             vsync_q;
    logic             w_vs_rise;
    logic [ROW_W-1:0] cap_row_q;
    logic [COL_W-1:0] cap_col_q;
    logic             overflow_q;

    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_fifo_rdata;
    logic [ENTRY_W-1:0] w_fifo_wdata;

    assign w_vs_rise    = VSYNC & ~vsync_q;
    assign w_fifo_wdata = {cap_row_q, cap_col_q, DATA_R0, DATA_G0, DATA_B0,
                           DATA_R1, DATA_G1, DATA_B1};

    // Registered VSYNC copy for rising-edge detection.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= VSYNC;
        end
    end

    // Capture counters advance on every valid pair, dropped or not, so the
    // tags of later pairs stay correct after a loss.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cap_row_q <= '0;
            cap_col_q <= '0;
        end else if (w_vs_rise) begin
            cap_row_q <= '0;
            cap_col_q <= '0;
        end else if (HSYNC) begin
            if (cap_col_q == COL_W'(WIDTH - 2)) begin
                cap_col_q <= '0;
                cap_row_q <= cap_row_q + ROW_W'(1);
            end else begin
                cap_col_q <= cap_col_q + COL_W'(2);
            end
        end
    end

    // Sticky loss flag: a pair arriving at a full FIFO with no pop is lost.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            overflow_q <= 1'b0;
        end else if (w_vs_rise) begin
            overflow_q <= 1'b0;
        end else if (HSYNC && w_fifo_full && !w_pop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;

    pix_pair_fifo #(
        .DW    (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .flush_i (w_vs_rise),
        .push_i  (HSYNC),
        .wdata_i (w_fifo_wdata),
        .pop_i   (w_pop),
        .rdata_o (w_fifo_rdata),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // Serializer FSM and address generator
    // ------------------------------------------------------------------
    state_t             state_q;
    state_t             state_d;
    logic [ENTRY_W-1:0] hold_q;
    logic [2:0]         k_q;
    logic [1:0]         p_q;
    logic [ADDR_W-1:0]  addr_q;

    logic               w_xfer;
    logic               w_last_col;
    logic               w_last_row;
    logic [ROW_W-1:0]   w_hold_row;
    logic [COL_W-1:0]   w_hold_col;
    logic [ROW_W-1:0]   w_new_row;
    logic [COL_W-1:0]   w_new_col;
    logic [ADDR_W-1:0]  w_base;

    assign w_hold_col = hold_q[48 +: COL_W];
    assign w_hold_row = hold_q[48 + COL_W +: ROW_W];
    assign w_new_col  = w_fifo_rdata[48 +: COL_W];
    assign w_new_row  = w_fifo_rdata[48 + COL_W +: ROW_W];
    assign w_last_col = (w_hold_col == COL_W'(WIDTH - 2));
    assign w_last_row = (w_hold_row == ROW_W'(HEIGHT - 1));
    assign w_xfer     = ((state_q == S_PIX) || (state_q == S_PAD)) && i_ready;

    // Row 0 lands at the bottom of the stored image.
    assign w_base = (ADDR_W'(HEIGHT - 1) - ADDR_W'(w_new_row)) * ADDR_W'(ROW_BYTES)
                  + ADDR_W'(w_new_col) * ADDR_W'(BYTES_PER_PIX);

    // State register; a new frame forces the serializer back to idle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
        end else if (w_vs_rise) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and pop decision; pops straight after the last pixel byte
    // so consecutive pairs stream without a bubble.
    always_comb begin
        state_d = state_q;
        w_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop   = 1'b1;
                    state_d = S_PIX;
                end
            end
            S_PIX: begin
                if (w_xfer && (k_q == 3'd5)) begin
                    if (w_last_col && (PAD > 0)) begin
                        state_d = S_PAD;
                    end else if (w_last_col && w_last_row) begin
                        state_d = S_DONE;
                    end else if (!w_fifo_empty) begin
                        w_pop   = 1'b1;
                        state_d = S_PIX;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_PAD: begin
                if (w_xfer && (p_q == 2'(PAD - 1))) begin
                    state_d = w_last_row ? S_DONE : S_IDLE;
                end
            end
            default: begin
                state_d = S_DONE;
            end
        endcase
    end

    // Holding register, byte index, pad index and running byte address.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_q <= '0;
            k_q    <= '0;
            p_q    <= '0;
            addr_q <= '0;
        end else if (!w_vs_rise) begin
            if (w_pop) begin
                hold_q <= w_fifo_rdata;
                k_q    <= '0;
                p_q    <= '0;
                addr_q <= w_base;
            end else if (w_xfer) begin
                addr_q <= addr_q + ADDR_W'(1);
                if (state_q == S_PIX) begin
                    k_q <= k_q + 3'd1;
                end else begin
                    p_q <= p_q + 2'd1;
                end
            end
        end
    end

    // Port outputs decoded from the current state; idle states drive zeros.
    always_comb begin
        o_valid    = 1'b0;
        o_byte     = 8'd0;
        o_addr     = '0;
        frame_done = 1'b0;
        case (state_q)
            S_PIX: begin
                o_valid = 1'b1;
                o_addr  = addr_q;
                case (k_q)
                    3'd0:    o_byte = hold_q[31:24];
                    3'd1:    o_byte = hold_q[39:32];
                    3'd2:    o_byte = hold_q[47:40];
                    3'd3:    o_byte = hold_q[7:0];
                    3'd4:    o_byte = hold_q[15:8];
                    3'd5:    o_byte = hold_q[23:16];
                    default: o_byte = 8'd0;
                endcase
            end
            S_PAD: begin
                o_valid = 1'b1;
                o_addr  = addr_q;
            end
            S_DONE: begin
                frame_done = 1'b1;
            end
            default: begin
                o_valid = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_bmp_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bmp_frame_writer
//  Description : Self-checking bench for bmp_frame_writer. DUT A is 4x2
//                (no row padding), DUT B is 2x2 (2 pad bytes per row); both
//                use a 2-entry FIFO and an 8-bit address.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bmp_frame_writer;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic       HRESETn, VSYNC;
    logic       hs_a, hs_b, rdy_a, rdy_b;
    logic [7:0] r0, g0, b0, r1, g1, b1;
    logic       va, vb, da, db, oa, ob;
    logic [7:0] ba, bb, aa, ab;

    bmp_frame_writer #(.WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(2), .ADDR_W(8)) dut_a (
        .HCLK(HCLK), .HRESETn(HRESETn), .VSYNC(VSYNC), .HSYNC(hs_a),
        .DATA_R0(r0), .DATA_G0(g0), .DATA_B0(b0),
        .DATA_R1(r1), .DATA_G1(g1), .DATA_B1(b1),
        .o_valid(va), .i_ready(rdy_a), .o_byte(ba), .o_addr(aa),
        .frame_done(da), .overflow(oa)
    );

    bmp_frame_writer #(.WIDTH(2), .HEIGHT(2), .FIFO_DEPTH(2), .ADDR_W(8)) dut_b (
        .HCLK(HCLK), .HRESETn(HRESETn), .VSYNC(VSYNC), .HSYNC(hs_b),
        .DATA_R0(r0), .DATA_G0(g0), .DATA_B0(b0),
        .DATA_R1(r1), .DATA_G1(g1), .DATA_B1(b1),
        .o_valid(vb), .i_ready(rdy_b), .o_byte(bb), .o_addr(ab),
        .frame_done(db), .overflow(ob)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } beat_t;

    beat_t q_a[$];
    beat_t q_b[$];
    int n_pass  = 0;
    int n_total = 0;
    int nb_a    = 0;
    int nb_b    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Pixel (r,c): R = r*16+c, G and B flip distinct bits so swaps show up.
    function automatic logic [7:0] pr(input int r, input int c);
        return 8'(r * 16 + c);
    endfunction
    function automatic logic [7:0] pg(input int r, input int c);
        return pr(r, c) ^ 8'h40;
    endfunction
    function automatic logic [7:0] pb(input int r, input int c);
        return pr(r, c) ^ 8'h80;
    endfunction

    // Expected BMP beats for one pair: B,G,R of each pixel, then row padding.
    task automatic sb_push(input bit b, input int r, input int c);
        int w, h, pad, rb, base;
        logic [7:0] by [6];
        beat_t e;
        w    = b ? 2 : 4;
        h    = 2;
        pad  = (4 - (w * 3) % 4) % 4;
        rb   = w * 3 + pad;
        base = (h - 1 - r) * rb + c * 3;
        by[0] = pb(r, c);     by[1] = pg(r, c);     by[2] = pr(r, c);
        by[3] = pb(r, c + 1); by[4] = pg(r, c + 1); by[5] = pr(r, c + 1);
        for (int k = 0; k < 6; k++) begin
            e.addr = 8'(base + k);
            e.data = by[k];
            if (b) q_b.push_back(e); else q_a.push_back(e);
        end
        if (c == w - 2) begin
            for (int p = 0; p < pad; p++) begin
                e.addr = 8'(base + 6 + p);
                e.data = 8'h00;
                if (b) q_b.push_back(e); else q_a.push_back(e);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge HCLK); #1;
        end
    endtask

    // One HSYNC cycle; expected bytes are queued only if the pair survives.
    task automatic push(input bit b, input int r, input int c, input bit keep);
        r0 = pr(r, c);     g0 = pg(r, c);     b0 = pb(r, c);
        r1 = pr(r, c + 1); g1 = pg(r, c + 1); b1 = pb(r, c + 1);
        if (b) hs_b = 1'b1; else hs_a = 1'b1;
        if (keep) sb_push(b, r, c);
        @(posedge HCLK); #1;
        hs_a = 1'b0;
        hs_b = 1'b0;
    endtask

    task automatic vs_pulse();
        VSYNC = 1'b1;
        q_a.delete();
        q_b.delete();
        @(posedge HCLK); #1;
        VSYNC = 1'b0;
    endtask

    task automatic wait_done(input bit b, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (b ? db : da) break;
            @(posedge HCLK); #1;
        end
        chk(b ? "frame_done_b" : "frame_done_a", 32'(b ? db : da), 32'd1);
    endtask

    task automatic wait_drain_a(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q_a.size() == 0) break;
            @(posedge HCLK); #1;
        end
        chk("drain_a", 32'(q_a.size()), 32'd0);
    endtask

    // Output monitors: scoreboard compare on each transfer and hold check
    // after every stalled cycle (skipped across reset and frame restart).
    logic       ps_a = 1'b0, ps_b = 1'b0, pvs_a = 1'b0, pvs_b = 1'b0;
    logic [7:0] pa_a, pd_a, pa_b, pd_b;

    always @(negedge HCLK) begin
        beat_t e;
        if (HRESETn && ps_a) begin
            chk("stall_valid_a", 32'(va), 32'd1);
            chk("stall_addr_a", 32'(aa), 32'(pa_a));
            chk("stall_byte_a", 32'(ba), 32'(pd_a));
        end
        if (HRESETn && va && rdy_a) begin
            nb_a++;
            if (q_a.size() == 0) begin
                chk("unexpected_beat_a", 32'(aa), 32'hFFFF_FFFF);
            end else begin
                e = q_a.pop_front();
                chk("addr_a", 32'(aa), 32'(e.addr));
                chk("byte_a", 32'(ba), 32'(e.data));
            end
        end
        ps_a  = HRESETn && va && !rdy_a && !(VSYNC && !pvs_a);
        pa_a  = aa;
        pd_a  = ba;
        pvs_a = VSYNC;
    end

    always @(negedge HCLK) begin
        beat_t e;
        if (HRESETn && ps_b) begin
            chk("stall_valid_b", 32'(vb), 32'd1);
            chk("stall_addr_b", 32'(ab), 32'(pa_b));
            chk("stall_byte_b", 32'(bb), 32'(pd_b));
        end
        if (HRESETn && vb && rdy_b) begin
            nb_b++;
            if (q_b.size() == 0) begin
                chk("unexpected_beat_b", 32'(ab), 32'hFFFF_FFFF);
            end else begin
                e = q_b.pop_front();
                chk("addr_b", 32'(ab), 32'(e.addr));
                chk("byte_b", 32'(bb), 32'(e.data));
            end
        end
        ps_b  = HRESETn && vb && !rdy_b && !(VSYNC && !pvs_b);
        pa_b  = ab;
        pd_b  = bb;
        pvs_b = VSYNC;
    end

    task automatic full_frame_a();
        push(1'b0, 0, 0, 1'b1); cyc(3);
        push(1'b0, 0, 2, 1'b1); cyc(3);
        push(1'b0, 1, 0, 1'b1); cyc(3);
        push(1'b0, 1, 2, 1'b1);
    endtask

    initial begin
        HRESETn = 1'b0; VSYNC = 1'b0;
        hs_a = 1'b0; hs_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;
        r0 = '0; g0 = '0; b0 = '0; r1 = '0; g1 = '0; b1 = '0;
        cyc(3);

        // Reset state
        chk("rst_valid", 32'(va), 32'd0);
        chk("rst_byte", 32'(ba), 32'd0);
        chk("rst_addr", 32'(aa), 32'd0);
        chk("rst_done", 32'(da), 32'd0);
        chk("rst_ovf", 32'(oa), 32'd0);
        chk("rst_valid_b", 32'(vb), 32'd0);
        HRESETn = 1'b1;
        cyc(2);

        // Frame on 4x2 with a ready sink
        vs_pulse();
        nb_a = 0;
        full_frame_a();
        wait_done(1'b0, 100);
        chk("f1_beats", 32'(nb_a), 32'd24);
        chk("f1_left", 32'(q_a.size()), 32'd0);
        chk("f1_ovf", 32'(oa), 32'd0);
        chk("f1_valid_in_done", 32'(va), 32'd0);

        // Frame on 2x2 with row padding
        vs_pulse();
        nb_b = 0;
        push(1'b1, 0, 0, 1'b1);
        push(1'b1, 1, 0, 1'b1);
        wait_done(1'b1, 100);
        chk("pad_beats", 32'(nb_b), 32'd16);
        chk("pad_left", 32'(q_b.size()), 32'd0);
        chk("pad_ovf", 32'(ob), 32'd0);

        // Frame with the sink toggling ready every cycle
        vs_pulse();
        nb_a = 0;
        for (int i = 0; i < 4; i++) begin
            push(1'b0, i / 2, (i % 2) * 2, 1'b1);
            for (int j = 0; j < 13; j++) begin
                @(posedge HCLK); #1;
                rdy_a = ~rdy_a;
            end
        end
        for (int j = 0; j < 200 && !da; j++) begin
            @(posedge HCLK); #1;
            rdy_a = ~rdy_a;
        end
        chk("tog_done", 32'(da), 32'd1);
        chk("tog_beats", 32'(nb_a), 32'd24);
        rdy_a = 1'b1;

        // Stalled sink under continuous HSYNC: pair 0 sits in the holding
        // register, pairs 1 and 2 fill the FIFO, pairs 3..9 are lost.
        vs_pulse();
        nb_a  = 0;
        rdy_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push(1'b0, i / 2, (i % 2) * 2, i < 3);
        end
        chk("ovf_set", 32'(oa), 32'd1);
        rdy_a = 1'b1;
        wait_drain_a(200);
        cyc(5);
        chk("ovf_beats", 32'(nb_a), 32'd18);
        chk("ovf_idle", 32'(va), 32'd0);
        chk("ovf_no_done", 32'(da), 32'd0);
        chk("ovf_sticky", 32'(oa), 32'd1);

        // Frame restart while the FIFO holds pairs
        vs_pulse();
        chk("vs_ovf_clr", 32'(oa), 32'd0);
        rdy_a = 1'b0;
        push(1'b0, 0, 0, 1'b0);
        push(1'b0, 0, 2, 1'b0);
        push(1'b0, 1, 0, 1'b0);
        cyc(2);
        chk("vs_pre_valid", 32'(va), 32'd1);
        vs_pulse();
        chk("vs_valid_drop", 32'(va), 32'd0);
        rdy_a = 1'b1;
        cyc(4);
        chk("vs_fifo_flushed", 32'(va), 32'd0);
        nb_a = 0;
        full_frame_a();
        wait_done(1'b0, 100);
        chk("vs_beats", 32'(nb_a), 32'd24);
        chk("vs_ovf", 32'(oa), 32'd0);

        // Asynchronous reset in the middle of a pixel
        vs_pulse();
        rdy_a = 1'b0;
        push(1'b0, 0, 0, 1'b0);
        cyc(2);
        chk("mid_valid", 32'(va), 32'd1);
        HRESETn = 1'b0;
        #1;
        chk("arst_valid", 32'(va), 32'd0);
        chk("arst_byte", 32'(ba), 32'd0);
        chk("arst_addr", 32'(aa), 32'd0);
        chk("arst_done", 32'(da), 32'd0);
        cyc(2);
        HRESETn = 1'b1;
        rdy_a = 1'b1;
        cyc(2);
        vs_pulse();
        nb_a = 0;
        full_frame_a();
        wait_done(1'b0, 100);
        chk("post_rst_beats", 32'(nb_a), 32'd24);
        chk("post_rst_ovf", 32'(oa), 32'd0);

        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
